serial_mag_cmp: RTL
===================

SERIAL_MAG_CMP -- requirements
Module: serial_mag_cmp

Interface
REQ-001 SHALL have parameter W, default 8: operand width in bits; even, minimum 2.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request to compare a and b; sampled only while ready=1.
REQ-005 SHALL have port a  input  W  first operand, unsigned; sampled only at an accepted start.
REQ-006 SHALL have port b  input  W  second operand, unsigned; sampled only at an accepted start.
REQ-007 SHALL have port ready  output  1  high when idle and able to accept start.
REQ-008 SHALL have port done_tick  output  1  one-cycle pulse when a comparison completes.
REQ-009 SHALL have port a_gt_b  output  1  registered result: a > b.
REQ-010 SHALL have port a_eq_b  output  1  registered result: a == b.
REQ-011 SHALL have port a_lt_b  output  1  registered result: a < b.

Function
REQ-012 SHALL implement a two-state FSM, IDLE and SCAN; ready = (state == IDLE), decoded from state only.
REQ-013 Accept: start=1 while IDLE at an edge -> copy a, b into internal registers, load pair index to W/2-1, enter SCAN.
REQ-014 SCAN SHALL examine one 2-bit pair per cycle, MSB pair first: {a[2i+1],a[2i]} vs {b[2i+1],b[2i]}, i = pair index.
REQ-015 Pair compare SHALL be unsigned 2-bit greater/less/equal.
REQ-016 Pair differs -> at that edge register result (gt or lt), clear the other two flags, pulse done_tick, return to IDLE (early termination).
REQ-017 Pair equal and index > 0 -> decrement index, stay in SCAN; no output change.
REQ-018 Pair equal and index == 0 -> register a_eq_b=1, gt=lt=0, pulse done_tick, return to IDLE.
REQ-019 Latency: done_tick high during the cycle after the j-th edge following the accepting edge, j = pairs examined (1..W/2); worst case W/2.
REQ-020 done_tick SHALL be registered and high for exactly one cycle per accepted start.
REQ-021 After the first completion, exactly one of a_gt_b/a_eq_b/a_lt_b SHALL be 1; flags hold until the next completion, including through the following SCAN.
REQ-022 start while in SCAN SHALL be ignored (no latch, no restart, no queuing); a, b changes during SCAN SHALL not affect the result.
REQ-023 Because ready=1 in the done_tick cycle, start in that cycle SHALL be accepted (back-to-back, no bubble).
REQ-024 Pair index SHALL be ceil(log2(W/2)) bits minimum (1 bit when W=2); it SHALL not wrap below 0.

Reset
REQ-025 reset_n=0 SHALL immediately (asynchronously) force state=IDLE, pair index=0, operand registers=0, done_tick=0, a_gt_b=a_eq_b=a_lt_b=0; ready=1.
REQ-026 Reset during SCAN SHALL abort the comparison: no done_tick, no result update, including on reset release.
REQ-027 First edge after reset_n deasserts SHALL already be able to accept start.

Verification (W=8 unless stated)
REQ-028 Start, a=0xA5, b=0x25 -> top pair 10 vs 00 -> done_tick one edge after accept; a_gt_b=1, eq=lt=0.
REQ-029 Start, a=0x12, b=0x13 -> pairs 00/00, 01/01, 00/00, 10/11 -> done_tick 4 edges after accept; a_lt_b=1. Start, a=b=0x3C -> done_tick after 4; a_eq_b=1.
REQ-030 Start a=b=0x00; at 2nd SCAN edge drive start=1, a=0xFF -> ignored, result a_eq_b=1 after 4; start in done_tick cycle with a=0x40, b=0x80 -> accepted, a_lt_b=1 one edge later, ready never low in between except during SCAN.
REQ-031 Start a=0x00, b=0x01, assert reset_n=0 asynchronously mid-cycle after 2nd SCAN edge -> outputs 0 immediately, ready=1, no done_tick after release.
REQ-032 W=2: all 16 (a,b) combinations -> done_tick one edge after each accept; flags match unsigned a>b, a==b, a<b.
REQ-033 Randomized W=8 and W=16, 1000 ops with random start timing -> flags match reference compare; done_tick count equals accepted starts.

Source files
------------

// File: rtl/serial_mag_cmp.sv
// Serial unsigned magnitude comparator: scans two W-bit operands one 2-bit
// pair per cycle, MSB pair first, and stops at the first differing pair.
module serial_mag_cmp #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         ready,
    output logic         done_tick,
    output logic         a_gt_b,
    output logic         a_eq_b,
    output logic         a_lt_b
);

    localparam int unsigned NP = W / 2;
    localparam int unsigned IW = (NP > 1) ? $clog2(NP) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nx;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    w_a_nx;
    logic [W-1:0]    w_b_nx;
    logic [IW-1:0]   r_idx;
    logic [IW-1:0]   w_idx_nx;
    logic            r_done;
    logic            w_done_nx;
    logic            r_gt;
    logic            r_eq;
    logic            r_lt;
    logic            w_gt_nx;
    logic            w_eq_nx;
    logic            w_lt_nx;
    logic [1:0]      w_pa;
    logic [1:0]      w_pb;

    // Select the operand pair addressed by the current pair index
    always_comb begin
        w_pa = 2'b00;
        w_pb = 2'b00;
        for (int unsigned i = 0; i < NP; i++) begin
            if (r_idx == IW'(i)) begin
                w_pa = r_a[2*i +: 2];
                w_pb = r_b[2*i +: 2];
            end
        end
    end

    // State, operand, index and result registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_idx   <= '0;
            r_done  <= 1'b0;
            r_gt    <= 1'b0;
            r_eq    <= 1'b0;
            r_lt    <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_a     <= w_a_nx;
            r_b     <= w_b_nx;
            r_idx   <= w_idx_nx;
            r_done  <= w_done_nx;
            r_gt    <= w_gt_nx;
            r_eq    <= w_eq_nx;
            r_lt    <= w_lt_nx;
        end
    end

    // Next-state logic: accept in IDLE, scan pairs with early termination
    always_comb begin
        w_state_nx = r_state;
        w_a_nx     = r_a;
        w_b_nx     = r_b;
        w_idx_nx   = r_idx;
        w_done_nx  = 1'b0;
        w_gt_nx    = r_gt;
        w_eq_nx    = r_eq;
        w_lt_nx    = r_lt;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_a_nx     = a;
                    w_b_nx     = b;
                    w_idx_nx   = IW'(NP - 1);
                    w_state_nx = SCAN;
                end
            end
            SCAN: begin
                if (w_pa > w_pb) begin
                    w_gt_nx    = 1'b1;
                    w_eq_nx    = 1'b0;
                    w_lt_nx    = 1'b0;
                    w_done_nx  = 1'b1;
                    w_state_nx = IDLE;
                end else if (w_pa < w_pb) begin
                    w_gt_nx    = 1'b0;
                    w_eq_nx    = 1'b0;
                    w_lt_nx    = 1'b1;
                    w_done_nx  = 1'b1;
                    w_state_nx = IDLE;
                end else if (r_idx == '0) begin
                    w_gt_nx    = 1'b0;
                    w_eq_nx    = 1'b1;
                    w_lt_nx    = 1'b0;
                    w_done_nx  = 1'b1;
                    w_state_nx = IDLE;
                end else begin
                    w_idx_nx   = r_idx - IW'(1);
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    assign ready     = (r_state == IDLE);
    assign done_tick = r_done;
    assign a_gt_b    = r_gt;
    assign a_eq_b    = r_eq;
    assign a_lt_b    = r_lt;

endmodule
